// File: rtl/decode_stage_hz_if.sv
// Decode-stage connection bundle: fetch handshake, write-back port, flush and
// the registered decode->execute bus. The stage itself uses the slave modport.
interface decode_stage_hz_if #(
  parameter int REG_BITS  = 5,
  parameter int REG_WIDTH = 32,
  parameter int PC_WIDTH  = 32,
  parameter int CTRL_SIZE = 21,
  parameter int CNT_WIDTH = 16
);
  localparam int BUS_W = 3*REG_BITS + CTRL_SIZE + 3*REG_WIDTH + PC_WIDTH;

  // Handshakes: a transfer happens on a posedge where valid && ready are both high.
  // A producer holds its payload stable while valid && !ready; ready never waits on
  // a later cycle's valid.
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  logic [PC_WIDTH-1:0]  in_pc;
  logic                 wb_en;
  logic [REG_BITS-1:0]  wb_reg;
  logic [REG_WIDTH-1:0] wb_data;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [BUS_W-1:0]     out_bus;
  logic [CNT_WIDTH-1:0] bubble_cnt;

  modport master (
    output in_valid, in_instr, in_pc, wb_en, wb_reg, wb_data, flush, out_ready,
    input  in_ready, out_valid, out_bus, bubble_cnt
  );

  modport slave (
    input  in_valid, in_instr, in_pc, wb_en, wb_reg, wb_data, flush, out_ready,
    output in_ready, out_valid, out_bus, bubble_cnt
  );
endinterface

// File: rtl/decode_stage_hz.sv
// RV32 decode stage: register file, immediate/control decode, load-use bubble
// insertion and flush. Define WB_BYPASS_EN for same-cycle write-back write-through.
module decode_stage_hz #(
  parameter  int REG_WIDTH = 32,
  parameter  int REG_COUNT = 32,
  parameter  int CTRL_SIZE = 21,
  parameter  int LOAD_BIT  = 3,
  parameter  int PC_WIDTH  = 32,
  parameter  int CNT_WIDTH = 16,
  localparam int REG_BITS  = $clog2(REG_COUNT)
) (
  input  logic             clk,
  input  logic             rstn,
  decode_stage_hz_if.slave dec
);
  localparam int BUS_W    = 3*REG_BITS + CTRL_SIZE + 3*REG_WIDTH + PC_WIDTH;
  localparam int CTRL_LSB = 3*REG_WIDTH + PC_WIDTH;

  logic [REG_WIDTH-1:0] r_rf [REG_COUNT];
  logic                 r_out_valid;
  logic [BUS_W-1:0]     r_out_bus;
  logic [CNT_WIDTH-1:0] r_bubble_cnt;

  logic [REG_BITS-1:0]  w_rs1, w_rs2, w_rd, w_out_rd;
  logic [REG_WIDTH-1:0] w_rdata1, w_rdata2, w_imm;
  logic [31:0]          w_imm32;
  logic [CTRL_SIZE-1:0] w_ctrl;
  logic [6:0]           w_opcode;
  logic                 w_out_load, w_hazard, w_in_ready, w_accept;

  assign w_opcode = dec.in_instr[6:0];
  assign w_rs1    = REG_BITS'(dec.in_instr[19:15]);
  assign w_rs2    = REG_BITS'(dec.in_instr[24:20]);
  assign w_rd     = REG_BITS'(dec.in_instr[11:7]);

  always_comb begin
    w_rdata1 = (w_rs1 == '0) ? '0 : r_rf[w_rs1];
    w_rdata2 = (w_rs2 == '0) ? '0 : r_rf[w_rs2];
`ifdef WB_BYPASS_EN
    if (dec.wb_en && dec.wb_reg == w_rs1 && w_rs1 != '0) w_rdata1 = dec.wb_data;
    if (dec.wb_en && dec.wb_reg == w_rs2 && w_rs2 != '0) w_rdata2 = dec.wb_data;
`endif
  end

  // Immediate generation: built at 32 bits, then sign-extended to REG_WIDTH.
  always_comb begin
    w_imm32 = '0;
    case (w_opcode)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
        w_imm32 = {{20{dec.in_instr[31]}}, dec.in_instr[31:20]};
      7'b0100011:
        w_imm32 = {{20{dec.in_instr[31]}}, dec.in_instr[31:25], dec.in_instr[11:7]};
      7'b1100011:
        w_imm32 = {{19{dec.in_instr[31]}}, dec.in_instr[31], dec.in_instr[7],
                   dec.in_instr[30:25], dec.in_instr[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        w_imm32 = {dec.in_instr[31:12], 12'b0};
      7'b1101111:
        w_imm32 = {{11{dec.in_instr[31]}}, dec.in_instr[31], dec.in_instr[19:12],
                   dec.in_instr[20], dec.in_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
    w_imm = REG_WIDTH'($signed(w_imm32));
  end

  // Control word: 0 regwrite, 1 alusrc, 2 memwrite, LOAD_BIT memread, 4 branch,
  // 5 jump, 6 memtoreg, 9:7 funct3, 10 funct7[5], 17:11 opcode, 18 lui, 19 auipc, 20 illegal.
  always_comb begin
    w_ctrl        = '0;
    w_ctrl[9:7]   = dec.in_instr[14:12];
    w_ctrl[10]    = dec.in_instr[30];
    w_ctrl[17:11] = w_opcode;
    case (w_opcode)
      7'b0000011: begin w_ctrl[0] = 1'b1; w_ctrl[1] = 1'b1; w_ctrl[6] = 1'b1; end
      7'b0100011: begin w_ctrl[1] = 1'b1; w_ctrl[2] = 1'b1; end
      7'b0110011: w_ctrl[0] = 1'b1;
      7'b0010011: begin w_ctrl[0] = 1'b1; w_ctrl[1] = 1'b1; end
      7'b1100011: w_ctrl[4] = 1'b1;
      7'b1101111: begin w_ctrl[0] = 1'b1; w_ctrl[5] = 1'b1; end
      7'b1100111: begin w_ctrl[0] = 1'b1; w_ctrl[1] = 1'b1; w_ctrl[5] = 1'b1; end
      7'b0110111: begin w_ctrl[0] = 1'b1; w_ctrl[1] = 1'b1; w_ctrl[18] = 1'b1; end
      7'b0010111: begin w_ctrl[0] = 1'b1; w_ctrl[1] = 1'b1; w_ctrl[19] = 1'b1; end
      7'b1110011: ;
      default:    w_ctrl[20] = 1'b1;
    endcase
    w_ctrl[LOAD_BIT] = (w_opcode == 7'b0000011);
  end

  assign w_out_rd   = r_out_bus[BUS_W-1 -: REG_BITS];
  assign w_out_load = r_out_bus[CTRL_LSB + LOAD_BIT];

  // Both rs fields are compared regardless of format; spurious stalls are harmless.
  assign w_hazard   = dec.in_valid && r_out_valid && w_out_load && (w_out_rd != '0) &&
                      ((w_out_rd == w_rs1) || (w_out_rd == w_rs2));
  assign w_in_ready = !dec.flush && !w_hazard && (!r_out_valid || dec.out_ready);
  assign w_accept   = dec.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < REG_COUNT; i++) r_rf[i] <= '0;
    end else if (dec.wb_en && dec.wb_reg != '0) begin
      r_rf[dec.wb_reg] <= dec.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_bus   <= '0;
    end else if (dec.flush) begin
      r_out_valid <= 1'b0;
    end else if (r_out_valid && !dec.out_ready) begin
      r_out_valid <= 1'b1;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_bus   <= {w_rd, w_rs1, w_rs2, w_ctrl, w_rdata1, w_rdata2, w_imm, dec.in_pc};
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bubble_cnt <= '0;
    end else if (w_hazard && dec.out_ready && !dec.flush && r_bubble_cnt != '1) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign dec.in_ready   = w_in_ready;
  assign dec.out_valid  = r_out_valid;
  assign dec.out_bus    = r_out_bus;
  assign dec.bubble_cnt = r_bubble_cnt;
endmodule
